// File: rtl/bin_cnt_pkg.sv
// Shared types and helpers for the programmable binary down-counter.
// Build option: BIN_DOWN_CNT_ONESHOT_EN selects one-shot terminal behaviour
// in the counter that imports this package.
package bin_cnt_pkg;

    // Controller states. DONE is only entered in the one-shot build.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_e;

    // Default count width and the widest count the helpers accept.
    localparam int unsigned CNT_W = 4;
    localparam int unsigned MAX_W = 16;

    // Terminal-count compare; callers zero-extend their count to MAX_W bits.
    function automatic logic cnt_at_zero(input logic [MAX_W-1:0] value);
        return (value == '0);
    endfunction

endpackage

// File: rtl/bin_down_counter.sv
// Programmable binary down-counter / interval timer with reload register,
// combinational terminal count for cascading and a registered done pulse.
// Build option BIN_DOWN_CNT_ONESHOT_EN: when defined, the terminal event parks
// the counter at zero in DONE; otherwise it reloads and keeps running.
module bin_down_counter
    import bin_cnt_pkg::*;
#(
    parameter int unsigned       WIDTH     = CNT_W,
    parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             QA,
    output logic             QB,
    output logic             QC,
    output logic             QD,
    output logic             tc,
    output logic             done,
    output logic             busy
);

    cnt_state_e       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;
    logic             at_zero;

    assign at_zero = cnt_at_zero(MAX_W'(q_q));

    // Next-state logic: load owns q/reload, stop beats start, counting is lowest.
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (en && !load) begin
                    if (at_zero) begin
                        done_d = 1'b1;
`ifdef BIN_DOWN_CNT_ONESHOT_EN
                        state_d = DONE;
`else
                        q_d = reload_q;
`endif
                    end else begin
                        q_d = q_q - WIDTH'(1);
                    end
                end
            end
            DONE: begin
                // stop has no meaning here; start rearms from the reload value
                if (start) begin
                    state_d = RUN;
                    q_d     = reload_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A load suppresses any count or terminal event in the same cycle.
        if (load) begin
            q_d      = load_val;
            reload_d = load_val;
        end
    end

    // State, count, reload value and done pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            q_q      <= RESET_VAL;
            reload_q <= RESET_VAL;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    // Outputs; tc stays combinational so a cascaded stage sees it this cycle.
    always_comb begin
        q    = q_q;
        QA   = q_q[0];
        QB   = q_q[1];
        QC   = q_q[2];
        QD   = q_q[3];
        busy = (state_q == RUN);
        tc   = (state_q == RUN) && at_zero && en;
        done = done_q;
    end

endmodule

// File: tb/tb_bin_down_counter.sv
// Self-checking bench for bin_down_counter (WIDTH=4): a constant vector table,
// hand-written multi-cycle sequences and randomized stimulus against a model.
module tb_bin_down_counter;

`ifdef BIN_DOWN_CNT_ONESHOT_EN
    localparam bit OS = 1'b1;
`else
    localparam bit OS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       load, start, stop, en;
    logic [3:0] load_val;
    logic [3:0] q;
    logic       QA, QB, QC, QD, tc, done, busy;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_q, m_rl;
    bit m_run, m_fin, m_done;

    bin_down_counter #(.WIDTH(4), .RESET_VAL(4'hF)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .en(en), .q(q),
        .QA(QA), .QB(QB), .QC(QC), .QD(QD),
        .tc(tc), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       l;
        logic [3:0] lv;
        logic       s;
        logic       p;
        logic       e;
        logic [3:0] eq;
        logic       eb;
        logic       ed;
        logic       et;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q = 15; m_rl = 15; m_run = 0; m_fin = 0; m_done = 0;
    endtask

    // Rules: load sets count/reload; running counts down on enabled cycles,
    // zero is the terminal event; stop halts, start resumes.
    task automatic model_step(input bit l, input int lv, input bit s, input bit p, input bit e);
        int oq;
        oq = m_q;
        m_done = 0;
        if (m_run) begin
            if (p) m_run = 0;
            else if (e && !l) begin
                if (oq > 0) m_q = oq - 1;
                else begin
                    m_done = 1;
                    if (OS) begin m_run = 0; m_fin = 1; end
                    else m_q = m_rl;
                end
            end
        end else if (m_fin) begin
            if (s) begin m_fin = 0; m_run = 1; m_q = m_rl; end
        end else if (s && !p) begin
            m_run = 1;
        end
        if (l) begin m_q = lv; m_rl = lv; end
    endtask

    task automatic apply(input bit l, input logic [3:0] lv, input bit s, input bit p, input bit e);
        load = l; load_val = lv; start = s; stop = p; en = e;
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_step(load, int'(load_val), start, stop, en);
        #1;
    endtask

    task automatic do_reset();
        apply(0, 0, 0, 0, 0);
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{0, 0, 0, 0, 0, 4'hF, 0, 0, 0};
        tbl[1]  = '{1, 3, 1, 0, 0, 4'd3, 1, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 1, 4'd2, 1, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 4'd2, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 1, 4'd1, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 1, 4'd0, 1, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 4'd0, 1, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 1, OS ? 4'd0 : 4'd3, !OS, 1, 1};
        tbl[8]  = '{0, 0, 0, 0, 0, OS ? 4'd0 : 4'd3, !OS, 0, 0};
        tbl[9]  = '{0, 0, 0, 1, 0, OS ? 4'd0 : 4'd3, 0, 0, 0};
        tbl[10] = '{0, 0, 1, 0, 0, 4'd3, 1, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 1, 4'd2, 1, 0, 0};
        tbl[12] = '{1, 9, 0, 1, 0, 4'd9, 0, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 1, 4'd9, 0, 0, 0};
        tbl[14] = '{0, 0, 1, 1, 0, 4'd9, 0, 0, 0};
        tbl[15] = '{0, 0, 1, 0, 1, 4'd9, 1, 0, 0};

        // Reset state and idle hold
        do_reset();
        for (int i = 0; i < 10; i++) begin
            apply(0, 0, 0, 0, (i % 2) == 1);
            chk("idle_tc", tc, 0);
            edge_step();
            chk("idle_q", q, 4'hF);
            chk("idle_qa_qd", {QD, QC, QB, QA}, 4'hF);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
        end

        // Constant vector table
        do_reset();
        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].l, tbl[i].lv, tbl[i].s, tbl[i].p, tbl[i].e);
            chk($sformatf("vec%0d_tc", i), tc, tbl[i].et);
            edge_step();
            chk($sformatf("vec%0d_q", i), q, tbl[i].eq);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].eb);
            chk($sformatf("vec%0d_done", i), done, tbl[i].ed);
        end

        // Free-running wrap and 16-cycle period from the reset value
        if (!OS) begin
            int k;
            do_reset();
            apply(0, 0, 1, 0, 0);
            edge_step();
            chk("per_start_busy", busy, 1);
            for (int i = 1; i <= 15; i++) begin
                apply(0, 0, 0, 0, 1);
                chk("per_tc_low", tc, 0);
                edge_step();
                chk("per_q", q, 16'(15 - i));
            end
            apply(0, 0, 0, 0, 1);
            chk("per_tc_high", tc, 1);
            edge_step();
            chk("per_wrap_q", q, 4'hF);
            chk("per_done", done, 1);
            k = 0;
            for (int i = 1; i <= 40; i++) begin
                apply(0, 0, 0, 0, 1);
                if (tc === 1'b1) begin
                    k = i;
                    break;
                end
                edge_step();
                if (i == 1) chk("per_done_once", done, 0);
            end
            chk("per_period", 16'(k), 16);
        end

        // Asynchronous reset mid-count aborts without a done pulse
        do_reset();
        apply(1, 4, 1, 0, 0);
        edge_step();
        apply(0, 0, 0, 0, 1);
        edge_step();
        edge_step();
        chk("ar_pre_q", q, 2);
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("ar_q", q, 4'hF);
        chk("ar_busy", busy, 0);
        edge_step();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 1);
            edge_step();
            chk("ar_no_done", done, 0);
            chk("ar_q_hold", q, 4'hF);
        end

`ifdef BIN_DOWN_CNT_ONESHOT_EN
        // One-shot: count 2,1,0, single done, park in DONE, rearm with start
        do_reset();
        apply(1, 2, 1, 0, 0);
        edge_step();
        chk("os_q2", q, 2);
        apply(0, 0, 0, 0, 1);
        edge_step();
        chk("os_q1", q, 1);
        edge_step();
        chk("os_q0", q, 0);
        chk("os_tc", tc, 1);
        edge_step();
        chk("os_done", done, 1);
        chk("os_busy", busy, 0);
        for (int i = 0; i < 10; i++) begin
            apply(0, 0, 0, i % 3 == 0, 1);
            chk("os_hold_tc", tc, 0);
            edge_step();
            chk("os_hold_q", q, 0);
            chk("os_hold_done", done, 0);
            chk("os_hold_busy", busy, 0);
        end
        apply(0, 0, 1, 0, 0);
        edge_step();
        chk("os_rearm_q", q, 2);
        chk("os_rearm_busy", busy, 1);
`endif

        // Randomized stimulus against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) != 0);
            chk("rnd_tc", tc, 16'(m_run && m_q == 0 && en));
            edge_step();
            chk("rnd_q", q, 16'(m_q));
            chk("rnd_qa_qd", {QD, QC, QB, QA}, 16'(m_q));
            chk("rnd_busy", busy, 16'(m_run));
            chk("rnd_done", done, 16'(m_done));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
